// File: rtl/video_timing_detector.sv
// rtl/video_timing_detector.sv - measures incoming video geometry, declares lock, emits aligned pixel coordinates; optional VIDEO_CHECKSUM_EN frame checksum
module video_timing_detector #(
  parameter int SYNC_ACTIVE_HIGH = 1,
  parameter int LOCK_FRAMES      = 2
) (
  input  logic        pixel_clock,
  input  logic        reset_n,
  input  logic        data_enable,
  input  logic        horz_sync,
  input  logic        vert_sync,
  input  logic [7:0]  red,
  input  logic [7:0]  green,
  input  logic [7:0]  blue,
  output logic [11:0] h_total,
  output logic [11:0] h_active,
  output logic [11:0] v_total,
  output logic [11:0] v_active,
  output logic        locked,
  output logic        frame_start,
  output logic        pixel_valid,
  output logic [11:0] pixel_x,
  output logic [11:0] pixel_y,
  output logic [7:0]  pixel_red,
  output logic [7:0]  pixel_green,
  output logic [7:0]  pixel_blue,
  output logic [31:0] frame_checksum
);
  localparam logic        SYNC_INV = (SYNC_ACTIVE_HIGH == 0);
  localparam logic [4:0]  LOCK_N   = 5'(LOCK_FRAMES);
  localparam logic [11:0] CNT_MAX  = 12'hFFF;

  typedef enum logic [1:0] {ST_UNLOCKED, ST_CHECKING, ST_LOCKED} state_t;

  // stage word layout: {de, hsync, vsync, red, green, blue}
  logic [26:0] a_q, a_d, b_q, b_d;
  logic [11:0] line_cnt_q, line_cnt_d, len_q, len_d, de_cnt_q, de_cnt_d, wid_q, wid_d;
  logic [11:0] lines_q, lines_d, act_q, act_d, x_q, x_d, y_q, y_d;
  logic        len_vld_q, len_vld_d, wid_vld_q, wid_vld_d, bad_q, bad_d, armed_q, armed_d;
  logic [47:0] cand_q, cand_d, prev_q, prev_d, geom_q, geom_d;
  logic        cand_vld_q, cand_vld_d, cand_ok_q, cand_ok_d, fs_q, fs_d;
  state_t      state_q, state_d;
  logic [3:0]  match_q, match_d;
  logic        load_geom;
  logic        a_de, b_de, hs_lead, vs_lead, de_rise, de_fall, sat;
  logic [11:0] line_len;
  logic [47:0] tuple;

  assign a_de    = a_q[26];
  assign b_de    = b_q[26];
  assign hs_lead = (a_q[25] ^ SYNC_INV) & ~(b_q[25] ^ SYNC_INV);
  assign vs_lead = (a_q[24] ^ SYNC_INV) & ~(b_q[24] ^ SYNC_INV);
  assign de_rise = a_de & ~b_de;
  assign de_fall = ~a_de & b_de;
  assign sat     = (line_cnt_q == CNT_MAX);

  // Two-stage input pipeline; stage B is the delayed pixel output
  always_comb begin
    a_d = {data_enable, horz_sync, vert_sync, red, green, blue};
    b_d = a_q;
  end

  // Line/frame measurement, candidate formation and coordinate tracking
  always_comb begin
    line_len   = line_cnt_q + 12'd1;
    line_cnt_d = hs_lead ? 12'd0 : (sat ? CNT_MAX : line_len);
    de_cnt_d   = de_cnt_q;
    if (de_rise)                            de_cnt_d = 12'd1;
    else if (a_de && de_cnt_q != CNT_MAX)   de_cnt_d = de_cnt_q + 12'd1;
    len_d = len_q; len_vld_d = len_vld_q; wid_d = wid_q; wid_vld_d = wid_vld_q; bad_d = bad_q;
    if (hs_lead) begin
      if (!len_vld_q) begin len_d = line_len; len_vld_d = 1'b1; end
      else if (line_len != len_q) bad_d = 1'b1;
    end
    if (de_fall) begin
      if (!wid_vld_q) begin wid_d = de_cnt_q; wid_vld_d = 1'b1; end
      else if (de_cnt_q != wid_q) bad_d = 1'b1;
    end
    lines_d = lines_q + {11'd0, hs_lead};
    act_d   = act_q + {11'd0, de_fall};
    // the tuple includes a line ending on the same cycle as the frame
    tuple      = {len_d, wid_d, lines_d, act_d};
    cand_d     = cand_q;
    prev_d     = prev_q;
    cand_ok_d  = cand_ok_q;
    armed_d    = armed_q;
    cand_vld_d = 1'b0;
    if (vs_lead) begin
      cand_vld_d = armed_q;
      armed_d    = 1'b1;
      if (armed_q) begin
        cand_d    = tuple;
        cand_ok_d = (tuple == prev_q) && !bad_d;
        prev_d    = tuple;
      end
      len_vld_d = 1'b0; wid_vld_d = 1'b0; bad_d = 1'b0; lines_d = 12'd0; act_d = 12'd0;
    end
    fs_d = vs_lead;
    x_d  = x_q;
    if (a_de) x_d = de_rise ? 12'd0 : x_q + 12'd1;
    y_d  = y_q;
    if (vs_lead)      y_d = 12'd0;
    else if (de_fall) y_d = y_q + 12'd1;
  end

  // Datapath registers
  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      a_q <= '0; b_q <= '0; line_cnt_q <= '0; len_q <= '0; de_cnt_q <= '0; wid_q <= '0;
      lines_q <= '0; act_q <= '0; x_q <= '0; y_q <= '0; len_vld_q <= 1'b0; wid_vld_q <= 1'b0;
      bad_q <= 1'b0; armed_q <= 1'b0; cand_q <= '0; prev_q <= '0; geom_q <= '0;
      cand_vld_q <= 1'b0; cand_ok_q <= 1'b0; fs_q <= 1'b0;
    end else begin
      a_q <= a_d; b_q <= b_d; line_cnt_q <= line_cnt_d; len_q <= len_d; de_cnt_q <= de_cnt_d;
      wid_q <= wid_d; lines_q <= lines_d; act_q <= act_d; x_q <= x_d; y_q <= y_d;
      len_vld_q <= len_vld_d; wid_vld_q <= wid_vld_d; bad_q <= bad_d; armed_q <= armed_d;
      cand_q <= cand_d; prev_q <= prev_d; geom_q <= geom_d;
      cand_vld_q <= cand_vld_d; cand_ok_q <= cand_ok_d; fs_q <= fs_d;
    end
  end

  // Lock FSM state register
  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_UNLOCKED;
      match_q <= 4'd0;
    end else begin
      state_q <= state_d;
      match_q <= match_d;
    end
  end

  // Lock FSM next state; a stalled line counter overrides everything
  always_comb begin
    state_d = state_q;
    match_d = match_q;
    if (sat) begin
      state_d = ST_UNLOCKED;
      match_d = 4'd0;
    end else if (cand_vld_q) begin
      case (state_q)
        ST_UNLOCKED: begin state_d = ST_CHECKING; match_d = 4'd0; end
        ST_CHECKING: begin
          if (!cand_ok_q) match_d = 4'd0;
          else if ({1'b0, match_q} + 5'd1 >= LOCK_N) begin state_d = ST_LOCKED; match_d = 4'd0; end
          else match_d = match_q + 4'd1;
        end
        ST_LOCKED: if (!cand_ok_q) begin state_d = ST_CHECKING; match_d = 4'd0; end
        default: begin state_d = ST_UNLOCKED; match_d = 4'd0; end
      endcase
    end
  end

  // Lock FSM outputs; geometry is captured only on entry to LOCKED
  always_comb begin
    locked    = (state_q == ST_LOCKED);
    load_geom = (state_q != ST_LOCKED) && (state_d == ST_LOCKED);
    geom_d    = load_geom ? cand_q : geom_q;
  end

  assign {h_total, h_active, v_total, v_active} = geom_q;
  assign frame_start = fs_q;
  assign pixel_valid = b_de;
  assign pixel_x     = x_q;
  assign pixel_y     = y_q;
  assign {pixel_red, pixel_green, pixel_blue} = b_q[23:0];

`ifdef VIDEO_CHECKSUM_EN
  logic [31:0] acc_q, acc_d, csum_q, csum_d, acc_sum;

  // Per-frame pixel sum, latched and cleared at each frame boundary
  always_comb begin
    acc_sum = acc_q + (a_de ? {8'h00, a_q[23:0]} : 32'h0);
    acc_d   = vs_lead ? 32'h0 : acc_sum;
    csum_d  = vs_lead ? acc_sum : csum_q;
  end

  // Checksum registers
  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_q  <= 32'h0;
      csum_q <= 32'h0;
    end else begin
      acc_q  <= acc_d;
      csum_q <= csum_d;
    end
  end

  assign frame_checksum = csum_q;
`else
  assign frame_checksum = 32'h0;
`endif
endmodule

// File: tb/tb_video_timing_detector.sv
// tb/tb_video_timing_detector.sv - randomized self-checking bench for video_timing_detector
module tb_video_timing_detector;
  localparam int LOCK_N = 2;
`ifdef VIDEO_CHECKSUM_EN
  localparam bit CS_EN = 1'b1;
`else
  localparam bit CS_EN = 1'b0;
`endif

  logic        pixel_clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        data_enable = 1'b0, horz_sync = 1'b0, vert_sync = 1'b0;
  logic [7:0]  red = 8'h0, green = 8'h0, blue = 8'h0;
  logic [11:0] h_total, h_active, v_total, v_active, pixel_x, pixel_y;
  logic        locked, frame_start, pixel_valid;
  logic [7:0]  pixel_red, pixel_green, pixel_blue;
  logic [31:0] frame_checksum;
  logic [47:0] geom_out;

  video_timing_detector #(.SYNC_ACTIVE_HIGH(1), .LOCK_FRAMES(LOCK_N)) dut (
    .pixel_clock(pixel_clock), .reset_n(reset_n), .data_enable(data_enable),
    .horz_sync(horz_sync), .vert_sync(vert_sync), .red(red), .green(green), .blue(blue),
    .h_total(h_total), .h_active(h_active), .v_total(v_total), .v_active(v_active),
    .locked(locked), .frame_start(frame_start), .pixel_valid(pixel_valid),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_red(pixel_red), .pixel_green(pixel_green),
    .pixel_blue(pixel_blue), .frame_checksum(frame_checksum)
  );

  assign geom_out = {h_total, h_active, v_total, v_active};

  always #5 pixel_clock = ~pixel_clock;

  typedef struct {
    bit          de;
    bit          fs;
    logic [23:0] rgb;
    int          x;
    int          y;
    bit          chk;
  } exp_t;

  exp_t        exp_q[$];
  int          vectors = 0, miscompares = 0;
  int          step_no = 0, last_hs = 0;
  bit          prev_vs = 0, prev_hs = 0, coord_ok = 0;
  logic [31:0] sum = 0, cs_latched = 0;
  // reference lock model: streak of consecutive clean matching frames
  bit          armed = 0, have_cand = 0, m_locked = 0, cur_bad = 0;
  int          streak = 0;
  logic [47:0] prev_tuple = 0, geom = 0, cur_tuple = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic model_close(input logic [47:0] t, input bit bad);
    if (!armed) armed = 1;
    else begin
      if (!have_cand) streak = 0;
      else if (t == prev_tuple && !bad) streak++;
      else streak = 0;
      have_cand  = 1;
      prev_tuple = t;
      if (streak == LOCK_N) geom = t;
      m_locked = (streak >= LOCK_N);
    end
  endtask

  task automatic step(input bit de, input bit hs, input bit vs, input logic [23:0] rgb,
                      input int x, input int y);
    exp_t e;
    @(posedge pixel_clock); #1;
    data_enable = de; horz_sync = hs; vert_sync = vs; {red, green, blue} = rgb;
    e.de = de; e.rgb = rgb; e.x = x; e.y = y; e.chk = coord_ok; e.fs = vs && !prev_vs;
    if (e.fs) begin
      cs_latched = sum + (de ? {8'h00, rgb} : 32'h0);
      sum = 0;
    end else if (de) sum += {8'h00, rgb};
    if (hs && !prev_hs) last_hs = step_no;
    prev_vs = vs; prev_hs = hs; step_no++;
    exp_q.push_back(e);
    @(negedge pixel_clock);
    if (exp_q.size() == 3) begin
      e = exp_q.pop_front();
      check_eq("pixel_valid", 64'(pixel_valid), 64'(e.de));
      check_eq("pixel_rgb", 64'({pixel_red, pixel_green, pixel_blue}), 64'(e.rgb));
      check_eq("frame_start", 64'(frame_start), 64'(e.fs));
      if (e.de && e.chk) begin
        check_eq("pixel_x", 64'(pixel_x), 64'(e.x));
        check_eq("pixel_y", 64'(pixel_y), 64'(e.y));
      end
    end
  endtask

  task automatic do_reset();
    data_enable = 0; horz_sync = 0; vert_sync = 0; {red, green, blue} = 24'h0;
    #2 reset_n = 1'b0;
    #1;
    check_eq("rst_geom", 64'(geom_out), 64'h0);
    check_eq("rst_pix", 64'({locked, frame_start, pixel_valid, pixel_x, pixel_y,
                             pixel_red, pixel_green, pixel_blue}), 64'h0);
    check_eq("rst_checksum", 64'(frame_checksum), 64'h0);
    armed = 0; have_cand = 0; m_locked = 0; streak = 0; geom = 0;
    exp_q.delete(); sum = 0; cs_latched = 0; prev_vs = 0; prev_hs = 0; coord_ok = 0;
    repeat (3) @(negedge pixel_clock);
    reset_n = 1'b1;
  endtask

  task automatic gen_frame(input int ht, input int ha, input int vt, input int va,
                           input int long_line, input int rst_line, input bit white);
    logic [47:0] geom_before;
    logic [23:0] rgb;
    bit          lock_before, de;
    lock_before = m_locked;
    geom_before = geom;
    model_close(cur_tuple, cur_bad);
    cur_tuple = {12'(ht), 12'(ha), 12'(vt), 12'(va)};
    cur_bad   = (long_line >= 0);
    coord_ok  = 1;
    for (int ln = 0; ln < vt; ln++) begin
      for (int px = 0; px < ht + ((ln == long_line) ? 1 : 0); px++) begin
        de  = (ln >= 3) && (ln < 3 + va) && (px >= 5) && (px < 5 + ha);
        rgb = white ? 24'hFFFFFF : 24'($urandom);
        if (ln == 3 && px == 5) rgb = {8'd12, 8'd34, 8'd56};
        if (!de) rgb = 24'h0;
        step(de, px < 3, ln < 2, rgb, px - 5, ln - 3);
        if (ln == 0 && px == 2) begin
          check_eq("locked_hold", 64'(locked), 64'(lock_before));
          check_eq("geom_hold", 64'(geom_out), 64'(geom_before));
          check_eq("checksum", 64'(frame_checksum), 64'(CS_EN ? cs_latched : 32'h0));
        end
        if (ln == 0 && px == 3) begin
          check_eq("locked", 64'(locked), 64'(m_locked));
          check_eq("geometry", 64'(geom_out), 64'(geom));
        end
        if (ln == rst_line && px == 5 + ha / 2) do_reset();
      end
    end
  endtask

  initial begin
    int ht, ha, vt, va;
    do_reset();
    ht = $urandom_range(30, 42); ha = $urandom_range(8, ht - 8);
    vt = $urandom_range(14, 20); va = $urandom_range(5, vt - 6);
    repeat (5) gen_frame(ht, ha, vt, va, -1, -1, 1'b0);
    gen_frame(ht, ha, vt, va, 3 + va / 2, -1, 1'b0);
    gen_frame(ht, ha, vt, va, -1, -1, 1'b1);
    repeat (2) gen_frame(ht, ha, vt, va, -1, -1, 1'b0);
    gen_frame(ht, ha, vt, va, -1, 3 + va / 2, 1'b0);
    repeat (5) gen_frame(ht, ha, vt, va, -1, -1, 1'b0);
    ht = ht + 2; ha = $urandom_range(8, ht - 8);
    va = $urandom_range(5, vt - 6);
    repeat (5) gen_frame(ht, ha, vt, va, -1, -1, 1'b0);
    for (int i = 0; i < 4200; i++) begin
      step(1'b0, 1'b0, 1'b0, 24'h0, 0, 0);
      if (step_no - 1 == last_hs + 4080) check_eq("locked_pre_sat", 64'(locked), 64'(m_locked));
      if (step_no - 1 == last_hs + 4110) begin
        have_cand = 0; streak = 0; m_locked = 0;
        check_eq("locked_sat", 64'(locked), 64'(m_locked));
        check_eq("geom_sat", 64'(geom_out), 64'(geom));
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
